// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : proc_pkg
// Description : Shared definitions for the 12-bit processor datapath: data
//               width, bus-attached register indices and the transfer
//               controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam int REG_WIDTH = 12;
    localparam int NUM_REGS  = 8;
    localparam int IDX_W     = $clog2(NUM_REGS);

    // Register indices on the shared bus
    localparam logic [IDX_W-1:0] IDX_AC  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_R1  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_R2  = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_R3  = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_R4  = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_R5  = IDX_W'(5);
    localparam logic [IDX_W-1:0] IDX_R6  = IDX_W'(6);
    localparam logic [IDX_W-1:0] IDX_MDR = IDX_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } xfer_state_t;

    // A transfer is legal only between two distinct, existing registers.
    function automatic logic xfer_legal(input int src, input int dst, input int n);
        return (src != dst) && (src < n) && (dst < n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : onehot_dec
// Description : Index to one-hot decoder with enable. All outputs are zero
//               when en is low or when idx does not select an existing bit.
// Ports       : idx    - binary index
//               en     - decode enable
//               onehot - one-hot result, bit idx set when enabled
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec #(
    parameter int IDX_W = 3,
    parameter int N     = 8
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (idx == IDX_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bus_xfer_ctrl
// Description : Register-to-register bus transfer controller. Accepts a
//               (source, destination) request, samples the source register
//               once, drives it onto the shared bus and pulses a single
//               destination write strobe. Illegal transfers run the same
//               four-cycle sequence but never write and flag err with done.
// Ports       : clk      - system clock, rising edge
//               reset    - asynchronous active-low reset
//               req      - transfer request, taken only while ready=1
//               src_sel  - source register index
//               dst_sel  - destination register index
//               src_data - all register outputs, reg i at [i*REG_WIDTH +: REG_WIDTH]
//               bus_out  - registered bus value, held between transfers
//               write_en - one-hot destination write strobe
//               ready    - controller idle
//               done     - one-cycle completion pulse
//               err      - one-cycle reject flag, coincident with done
// Revision    : 1.0 - initial release
// ============================================================================
module bus_xfer_ctrl #(
    parameter  int REG_WIDTH = proc_pkg::REG_WIDTH,
    parameter  int NUM_REGS  = proc_pkg::NUM_REGS,
    localparam int SEL_W     = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req,
    input  logic [SEL_W-1:0]              src_sel,
    input  logic [SEL_W-1:0]              dst_sel,
    input  logic [NUM_REGS*REG_WIDTH-1:0] src_data,
    output logic [REG_WIDTH-1:0]          bus_out,
    output logic [NUM_REGS-1:0]           write_en,
    output logic                          ready,
    output logic                          done,
    output logic                          err
);

    import proc_pkg::*;

    xfer_state_t          r_state;
    logic [SEL_W-1:0]     r_src;
    logic [SEL_W-1:0]     r_dst;

    logic [REG_WIDTH-1:0] w_regs [NUM_REGS];
    logic                 w_legal;
    logic [NUM_REGS-1:0]  w_dst_onehot;

    // Split the flat register bus into an indexable array.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
        assign w_regs[g] = src_data[g*REG_WIDTH +: REG_WIDTH];
    end

    assign w_legal = xfer_legal(int'(r_src), int'(r_dst), NUM_REGS);

    onehot_dec #(
        .IDX_W (SEL_W),
        .N     (NUM_REGS)
    ) u_dst_dec (
        .idx    (r_dst),
        .en     (w_legal),
        .onehot (w_dst_onehot)
    );

    // bus_out doubles as the transfer hold register: it is loaded from the
    // source on the FETCH edge only, so later source changes cannot reach
    // the destination, and a rejected transfer leaves it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            bus_out  <= '0;
            write_en <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_src   <= src_sel;
                        r_dst   <= dst_sel;
                        ready   <= 1'b0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_legal) begin
                        bus_out <= w_regs[r_src];
                    end
                    write_en <= w_dst_onehot;
                    r_state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    write_en <= '0;
                    done     <= 1'b1;
                    err      <= ~w_legal;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_xfer_ctrl
// Description : Self-checking bench for bus_xfer_ctrl: directed vector table,
//               back-to-back and reset-abort sequences, and random transfers
//               against a transfer-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_xfer_ctrl;
    import proc_pkg::*;

    localparam int W = 12;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           req;
    logic [2:0]     src_sel;
    logic [2:0]     dst_sel;
    logic [N*W-1:0] src_data;
    logic [W-1:0]   bus_out;
    logic [N-1:0]   write_en;
    logic           ready;
    logic           done;
    logic           err;

    logic [W-1:0]   regs_in [N];
    logic [W-1:0]   dest_q  [N];
    logic [W-1:0]   last_bus;
    int             n_checks = 0;
    int             n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign src_data[g*W +: W] = regs_in[g];
    end

    // Destination registers: capture the bus when their strobe is high.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (write_en[i]) dest_q[i] <= bus_out;
        end
    end

    bus_xfer_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .src_sel  (src_sel),
        .dst_sel  (dst_sel),
        .src_data (src_data),
        .bus_out  (bus_out),
        .write_en (write_en),
        .ready    (ready),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        logic [2:0]   s;
        logic [2:0]   d;
        logic [W-1:0] data;
        logic [N-1:0] we;
        bit           er;
        logic [W-1:0] bus;
        bit           chg;
        bit           pulse;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 20 && ready !== 1'b1; k++) tick();
        if (ready !== 1'b1) check("ready timeout", 32'(ready), 1);
    endtask

    // One complete transfer, checked cycle by cycle from E0 to E3.
    task automatic xfer(input logic [2:0] s, input logic [2:0] d, input logic [W-1:0] data,
                        input logic [N-1:0] exp_we, input bit exp_err, input logic [W-1:0] exp_bus,
                        input bit chg, input bit pulse);
        regs_in[s] = data;
        wait_ready();
        req = 1'b1; src_sel = s; dst_sel = d;
        tick(); // E0
        req = 1'b0; src_sel = 3'($urandom); dst_sel = 3'($urandom);
        check("E0 ready", 32'(ready), 0);
        check("E0 write_en", 32'(write_en), 0);
        check("E0 done", 32'(done), 0);
        if (pulse) req = 1'b1;
        tick(); // E1
        req = 1'b0;
        check("E1 write_en", 32'(write_en), 32'(exp_we));
        check("E1 bus_out", 32'(bus_out), 32'(exp_bus));
        check("E1 done", 32'(done), 0);
        check("E1 ready", 32'(ready), 0);
        if (chg) regs_in[s] = 12'h0FF;
        tick(); // E2
        check("E2 write_en", 32'(write_en), 0);
        check("E2 done", 32'(done), 1);
        check("E2 err", 32'(err), 32'(exp_err));
        check("E2 bus_out", 32'(bus_out), 32'(exp_bus));
        check("E2 ready", 32'(ready), 0);
        if (!exp_err) check("dest value", 32'(dest_q[d]), 32'(exp_bus));
        tick(); // E3
        check("E3 ready", 32'(ready), 1);
        check("E3 done", 32'(done), 0);
        check("E3 err", 32'(err), 0);
        check("E3 bus_out", 32'(bus_out), 32'(exp_bus));
        if (pulse) begin
            tick();
            check("ignored req ready", 32'(ready), 1);
            check("ignored req write_en", 32'(write_en), 0);
        end
        last_bus = exp_bus;
    endtask

    initial begin
        logic [2:0]   rs, rd;
        logic [W-1:0] rdata, snap;
        bit           legal;

        tbl[0] = '{IDX_R1, IDX_AC, 12'hE08, 8'b0000_0001, 1'b0, 12'hE08, 1'b1, 1'b0};
        tbl[1] = '{IDX_R3, IDX_R3, 12'h5A5, 8'b0000_0000, 1'b1, 12'hE08, 1'b0, 1'b0};
        tbl[2] = '{IDX_MDR, IDX_R4, 12'h123, 8'b0001_0000, 1'b0, 12'h123, 1'b0, 1'b1};
        tbl[3] = '{IDX_AC, IDX_MDR, 12'hFFF, 8'b1000_0000, 1'b0, 12'hFFF, 1'b0, 1'b0};
        tbl[4] = '{IDX_R6, IDX_R6, 12'h000, 8'b0000_0000, 1'b1, 12'hFFF, 1'b0, 1'b0};
        tbl[5] = '{IDX_R2, IDX_R1, 12'h000, 8'b0000_0010, 1'b0, 12'h000, 1'b0, 1'b0};

        for (int i = 0; i < N; i++) regs_in[i] = '0;
        reset = 1'b0; req = 1'b0; src_sel = '0; dst_sel = '0;
        last_bus = '0;

        // Reset held for two cycles
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("reset ready", 32'(ready), 1);
        check("reset bus_out", 32'(bus_out), 0);
        check("reset write_en", 32'(write_en), 0);
        check("reset done", 32'(done), 0);
        check("reset err", 32'(err), 0);

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            xfer(tbl[i].s, tbl[i].d, tbl[i].data, tbl[i].we, tbl[i].er, tbl[i].bus,
                 tbl[i].chg, tbl[i].pulse);
        end

        // Back-to-back: req held 8 cycles, dst 2 then 5
        wait_ready();
        regs_in[1] = 12'h3C7;
        req = 1'b1; src_sel = 3'd1; dst_sel = 3'd2;
        for (int k = 0; k < 8; k++) begin
            logic [N-1:0] exp_we;
            tick();
            if (k == 3) dst_sel = 3'd5;
            if (k == 7) req = 1'b0;
            exp_we = (k == 1) ? 8'b0000_0100 : (k == 5) ? 8'b0010_0000 : 8'b0000_0000;
            check($sformatf("b2b write_en c%0d", k), 32'(write_en), 32'(exp_we));
            check($sformatf("b2b done c%0d", k), 32'(done), (k == 2 || k == 6) ? 1 : 0);
            check($sformatf("b2b ready c%0d", k), 32'(ready), (k == 3 || k == 7) ? 1 : 0);
        end
        tick();
        check("b2b idle write_en", 32'(write_en), 0);
        check("b2b dest2", 32'(dest_q[2]), 32'h3C7);
        check("b2b dest5", 32'(dest_q[5]), 32'h3C7);
        last_bus = 12'h3C7;

        // Random transfers against the transfer-level model
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) regs_in[i] = 12'($urandom);
            rs    = 3'($urandom_range(0, 7));
            rd    = ($urandom_range(0, 3) == 0) ? rs : 3'($urandom_range(0, 7));
            rdata = 12'($urandom);
            legal = (rs != rd);
            xfer(rs, rd, rdata, legal ? 8'(1 << rd) : 8'h00, !legal,
                 legal ? rdata : last_bus, 1'b0, 1'b0);
        end

        // Reset while write_en is high
        wait_ready();
        snap = dest_q[4];
        regs_in[2] = 12'hABC;
        req = 1'b1; src_sel = 3'd2; dst_sel = 3'd4;
        tick(); // E0
        req = 1'b0;
        tick(); // E1
        check("abort pre write_en", 32'(write_en), 32'h10);
        reset = 1'b0;
        #1;
        check("abort write_en", 32'(write_en), 0);
        check("abort bus_out", 32'(bus_out), 0);
        check("abort done", 32'(done), 0);
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("post-abort done c%0d", k), 32'(done), 0);
            check($sformatf("post-abort ready c%0d", k), 32'(ready), 1);
            check($sformatf("post-abort write_en c%0d", k), 32'(write_en), 0);
        end
        check("abort dest untouched", 32'(dest_q[4]), 32'(snap));
        last_bus = '0;

        // After reset: a reject keeps the cleared bus, then a normal transfer
        xfer(3'd5, 3'd5, 12'h777, 8'h00, 1'b1, 12'h000, 1'b0, 1'b0);
        xfer(3'd6, 3'd3, 12'h9D1, 8'b0000_1000, 1'b0, 12'h9D1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
